// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, default geometry
// and the bytes-per-word derivation.
package prog_loader_pkg;

    localparam int PSIZE_DEF = 4;
    localparam int CSIZE_DEF = 11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int bpw_f(input int csize);
        return (csize + 7) / 8;
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: one synchronous write port, one asynchronous read port,
// no reset so contents survive a loader reset.
module prog_ram #(
    parameter int Psize = 4,
    parameter int Csize = 11
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [Psize-1:0] i_waddr,
    input  logic [Csize-1:0] i_wdata,
    input  logic [Psize-1:0] i_raddr,
    output logic [Csize-1:0] o_rdata
);

    logic [Csize-1:0] r_mem [2**Psize];

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words into prog_ram,
// then compares a trailing modulo-256 checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int Psize = PSIZE_DEF,
    parameter int Csize = CSIZE_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Psize-1:0] addr,
    output logic [Csize-1:0] controlWord,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BPW = bpw_f(Csize);
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int AW  = BPW * 8;
    localparam logic [BIW-1:0]   LAST_BYTE = BIW'(BPW - 1);
    localparam logic [Psize-1:0] LAST_ADDR = {Psize{1'b1}};

    state_t           r_state, w_next;
    logic [Psize-1:0] r_waddr;
    logic [BIW-1:0]   r_bidx;
    logic [7:0]       r_sum;
    logic             r_err;
    logic [AW-1:0]    r_asm, w_asm;
    logic             w_xfer, w_last_byte, w_we;

    // Transfer qualifier derived from state, not from in_ready, to keep the
    // next-state logic free of a combinational loop.
    assign w_xfer      = in_valid && (r_state == S_RECV || r_state == S_CHECK);
    assign w_last_byte = (r_bidx == LAST_BYTE);
    assign w_we        = (r_state == S_RECV) && w_xfer && w_last_byte;
    assign err         = r_err;

    always_comb begin
        w_asm = r_asm;
        w_asm[{r_bidx, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RECV;
            end
            S_RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_we && r_waddr == LAST_ADDR) w_next = S_CHECK;
            end
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_waddr <= '0;
            r_bidx  <= '0;
            r_sum   <= '0;
            r_err   <= 1'b0;
            r_asm   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_waddr <= '0;
                        r_bidx  <= '0;
                        r_sum   <= '0;
                        r_err   <= 1'b0;
                        r_asm   <= '0;
                    end
                end
                S_RECV: begin
                    if (w_xfer) begin
                        r_sum <= r_sum + in_data;
                        r_asm <= w_asm;
                        if (w_last_byte) begin
                            r_bidx <= '0;
                            if (r_waddr != LAST_ADDR) r_waddr <= r_waddr + 1'b1;
                        end else begin
                            r_bidx <= r_bidx + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_xfer) r_err <= (in_data != r_sum);
                end
                default: ;
            endcase
        end
    end

    // High bits of the final byte fall off here; the sum above still saw them.
    prog_ram #(
        .Psize(Psize),
        .Csize(Csize)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (r_waddr),
        .i_wdata (w_asm[Csize-1:0]),
        .i_raddr (addr),
        .o_rdata (controlWord)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: full loads, bad checksum, backpressure,
// truncated high bits, reset mid-load and start while busy.
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  addr;
    logic [10:0] controlWord;
    logic        busy, done, err;

    int nvec = 0;
    int nmis = 0;

    logic [7:0]  ld_b [32];
    logic [10:0] exp_mem [16];

    typedef struct {
        logic [3:0]  a;
        logic [10:0] w;
    } rd_vec_t;
    rd_vec_t tbl [4];

    prog_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .addr        (addr),
        .controlWord (controlWord),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill_words(input logic [10:0] base, input int step);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = {5'd0, 11'(base + 11'(i * step))};
            ld_b[2*i]   = w[7:0];
            ld_b[2*i+1] = w[15:8];
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int duty);
        int guard;
        bit sent;
        guard = 0;
        sent  = 0;
        while (!sent) begin
            @(negedge clock);
            if ($urandom_range(0, 99) < duty) begin
                in_valid = 1'b1;
                in_data  = b;
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            #1;
            if (in_valid && in_ready) begin
                @(posedge clock);
                sent = 1;
            end else if (++guard > 2000) begin
                nvec++;
                nmis++;
                $display("FAIL send_byte_timeout: in_ready never seen, expected 1");
                $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
                $fatal(1, "stalled");
            end
        end
    endtask

    task automatic check_mem(input string nm);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            chk(nm, {21'd0, controlWord}, {21'd0, exp_mem[a]});
        end
    endtask

    // nbytes < 32 stops mid-load with no checksum; mid_start_at pulses start
    // before that byte index.
    task automatic do_load(input int adj, input int duty, input int mid_start_at, input int nbytes);
        logic [7:0] sum;
        logic [15:0] w;
        sum = 8'd0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_rdy", {31'd0, in_ready}, 32'd1);
        chk("start_err_clr", {31'd0, err}, 32'd0);
        for (int k = 0; k < nbytes; k++) begin
            if (k == mid_start_at) begin
                @(negedge clock);
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clock);
                start = 1'b0;
                chk("busy_start_ignored", {31'd0, busy}, 32'd1);
            end
            send_byte(ld_b[k], duty);
            sum = sum + ld_b[k];
        end
        if (nbytes == 32) begin
            send_byte(8'(sum + 8'(adj)), duty);
            @(negedge clock);
            in_valid = 1'b0;
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("done_busy", {31'd0, busy}, 32'd1);
            chk("done_rdy", {31'd0, in_ready}, 32'd0);
            chk("done_err", {31'd0, err}, (adj != 0) ? 32'd1 : 32'd0);
            @(negedge clock);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("err_held", {31'd0, err}, (adj != 0) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < nbytes / 2; i++) begin
            w = {ld_b[2*i+1], ld_b[2*i]};
            exp_mem[i] = w[10:0];
        end
    endtask

    initial begin
        tbl[0] = '{a: 4'd0,  w: 11'h7F0};
        tbl[1] = '{a: 4'd5,  w: 11'h7F5};
        tbl[2] = '{a: 4'd15, w: 11'h7FF};
        tbl[3] = '{a: 4'd10, w: 11'h7FA};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; addr = 4'd0;
        repeat (2) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_rdy", {31'd0, in_ready}, 32'd0);

        // First good load establishes memory contents
        fill_words(11'h123, 5);
        do_load(0, 100, -1, 32);
        check_mem("mem_first");

        // Bad checksum still writes the new words
        fill_words(11'h7F0, 1);
        do_load(1, 100, -1, 32);
        check_mem("mem_badsum");

        // Same words, 30% valid duty, good checksum; start clears err
        do_load(0, 30, -1, 32);
        for (int i = 0; i < 4; i++) begin
            addr = tbl[i].a;
            #1;
            chk("tbl_read", {21'd0, controlWord}, {21'd0, tbl[i].w});
        end
        check_mem("mem_bp");

        // 0xFF high byte: only 3 bits kept, full byte summed
        fill_words(11'h200, 1);
        ld_b[0] = 8'hAA;
        ld_b[1] = 8'hFF;
        do_load(0, 100, -1, 32);
        addr = 4'd0;
        #1;
        chk("hibits_word0", {21'd0, controlWord}, 32'h7AA);
        check_mem("mem_hibits");

        // Reset after word 3's first byte
        fill_words(11'h055, 1);
        do_load(0, 100, -1, 7);
        @(negedge clock);
        in_valid = 1'b0;
        addr = 4'd3;
        #1;
        chk("partial_word_old", {21'd0, controlWord}, {21'd0, exp_mem[3]});
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rdy", {31'd0, in_ready}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("postrst_rdy", {31'd0, in_ready}, 32'd0);
        check_mem("mem_midrst");

        // Start pulsed mid-RECV must be ignored
        fill_words(11'h0C0, 3);
        do_load(0, 100, 9, 32);
        check_mem("mem_midstart");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Psize, default 4, program address width; memory depth is 2^Psize words.
REQ-002 Csize, default 11, control-word width; bytes per word BPW = ceil(Csize/8), 2 at default.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a full program load.
REQ-006 in_data  input  8  load byte stream.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 addr  input  Psize  read address from the sequencer.
REQ-010 controlWord  output  Csize  memory word at addr.
REQ-011 busy  output  1  a load is in progress.
REQ-012 done  output  1  one-cycle pulse when a load completes, good or bad.
REQ-013 err  output  1  checksum mismatch on the last load; held until the next accepted start.

Function
REQ-014 A byte transfers only on a rising edge with in_valid and in_ready both high; in_data is ignored otherwise.
REQ-015 FSM states: IDLE, RECV, CHECK, DONE.
REQ-016 IDLE: in_ready=0, busy=0; start=1 moves to RECV, clears the word address, byte index, running sum and err.
REQ-017 RECV: in_ready=1, busy=1; bytes arrive little-endian, least-significant byte first, BPW bytes per word, words in address order 0..2^Psize-1.
REQ-018 Bits of the final byte above Csize are discarded from the word but still counted in the checksum.
REQ-019 On the edge that accepts the last byte of a word, the assembled word is written at the current word address; write latency is one edge.
REQ-020 After the write of word 2^Psize-1, the FSM moves to CHECK; the word address does not wrap.
REQ-021 CHECK: in_ready=1, busy=1; one checksum byte is accepted, and err is set if it differs from the 8-bit modulo-256 sum of all preceding load bytes; next state DONE.
REQ-022 DONE: busy=1, in_ready=0, done=1 for exactly one cycle; next state IDLE.
REQ-023 start is ignored in every state except IDLE.
REQ-024 in_valid gaps of any length stall RECV and CHECK with no state loss.
REQ-025 controlWord is a combinational read of memory at addr, valid in every state.
REQ-026 If addr equals the address being written, controlWord shows the old word until the write edge.
REQ-027 A mid-load word does not alter memory until its final byte is accepted.

Reset
REQ-028 reset asserted, at any time: state IDLE, in_ready=0, busy=0, done=0, err=0, and all counters and the sum cleared.
REQ-029 Memory contents are not cleared by reset.
REQ-030 A load interrupted by reset leaves every already-written word intact; the partial word is discarded.
REQ-031 Memory contents are undefined until the first completed load.

Structure
REQ-032 The shared definitions package holds the FSM state enum, the BPW derivation and the default Psize/Csize constants.
REQ-033 Storage is one sub-module, prog_ram: 2^Psize x Csize, one synchronous write port, one asynchronous read port, no reset.
REQ-034 prog_loader holds the FSM, counters, byte assembly and checksum, and instantiates prog_ram.

Verification
REQ-035 Good load: start, 32 bytes forming words i -> 11'h7F0+i, correct sum byte -> one done pulse, err=0, and addr=5 reads 11'h7F5.
REQ-036 Bad checksum: same load with sum byte +1 -> done pulses, err=1, memory holds the new words, and the next start clears err.
REQ-037 Backpressure: in_valid random 30% duty -> identical memory and done timing relative to the last accepted byte.
REQ-038 Discarded high bits: byte pair 8'hAA,8'hFF for word 0 -> controlWord=11'h7AA, and the sum includes 8'hFF.
REQ-039 Reset mid-load after word 3's first byte -> IDLE, busy=0, words 0-2 new, word 3 unchanged.
REQ-040 Start while busy, pulsed in RECV -> no effect on counters, and the load completes normally.
